// File: rtl/ad_tp_chk_if.sv
// Bus bundle for the AD test-pattern checker: sample stream and config in,
// lock/error status and counters out, plus the checker state for debug.
interface ad_tp_chk_if;
   // ad_vld qualifies ad_data for exactly one cycle; there is no backpressure,
   // every cycle with ad_vld high carries a sample the checker must consume.
   logic [23:0] ad_data;
   logic        ad_vld;
   logic [7:0]  cfg_ad_tp;
   logic        chk_clr;
   logic        chk_lock;
   logic        chk_err;
   logic [15:0] chk_err_cnt;
   logic [31:0] chk_smp_cnt;
   logic [1:0]  chk_state;

   modport master (
      output ad_data, ad_vld, cfg_ad_tp, chk_clr,
      input  chk_lock, chk_err, chk_err_cnt, chk_smp_cnt, chk_state
   );

   modport slave (
      input  ad_data, ad_vld, cfg_ad_tp, chk_clr,
      output chk_lock, chk_err, chk_err_cnt, chk_smp_cnt, chk_state
   );
endinterface

// File: rtl/ad_tp_chk.sv
// AD test-pattern checker: seeds from the stream, locks after four predicted
// matches, then free-runs its expectation and counts mismatches.
module ad_tp_chk (
   input  logic        clk_sys,
   input  logic        rst_n,
   ad_tp_chk_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEEK = 2'd1;
   localparam logic [1:0] ST_LOCK = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [7:0]  cfg_q;
   logic [23:0] exp_q, exp_d;
   logic [2:0]  match_q, match_d;
   logic [2:0]  miss_q, miss_d;
   logic        seeded_q, seeded_d;
   logic        lock_q;
   logic        err_q, err_d;
   logic [15:0] err_cnt_q, err_cnt_d;
   logic [31:0] smp_cnt_q, smp_cnt_d;
   logic [1:0]  mode;
   logic        cfg_chg;
   logic        data_hit;

   function automatic logic [23:0] next_val(input logic [1:0] m, input logic [23:0] x);
      logic [23:0] r;
      case (m)
         2'd1:    r = x + 24'd1;
         2'd2:    r = ~x;
         2'd3:    r = 24'h5A5A5A;
         default: r = x;
      endcase
      return r;
   endfunction

   // Selector values above 3 behave exactly like "off".
   assign mode     = (bus.cfg_ad_tp[7:2] == 6'd0) ? bus.cfg_ad_tp[1:0] : 2'd0;
   assign cfg_chg  = (bus.cfg_ad_tp != cfg_q);
   assign data_hit = (bus.ad_data == exp_q);

   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      match_d   = match_q;
      miss_d    = miss_q;
      seeded_d  = seeded_q;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      smp_cnt_d = smp_cnt_q;

      if (cfg_chg) begin
         // A config change discards any sample arriving in the same cycle.
         state_d  = (mode == 2'd0) ? ST_IDLE : ST_SEEK;
         match_d  = 3'd0;
         miss_d   = 3'd0;
         seeded_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (mode != 2'd0) state_d = ST_SEEK;
            end
            ST_SEEK: begin
               if (bus.ad_vld) begin
                  exp_d = next_val(mode, bus.ad_data);
                  if (!seeded_q) begin
                     seeded_d = 1'b1;
                  end else if (data_hit) begin
                     if (match_q == 3'd3) begin
                        state_d = ST_LOCK;
                        match_d = 3'd0;
                        miss_d  = 3'd0;
                     end else begin
                        match_d = match_q + 3'd1;
                     end
                  end else begin
                     match_d = 3'd0;
                  end
               end
            end
            ST_LOCK: begin
               if (bus.ad_vld) begin
                  // Free-running expectation: one bad sample costs one error.
                  exp_d = next_val(mode, exp_q);
                  if (smp_cnt_q != 32'hFFFF_FFFF) smp_cnt_d = smp_cnt_q + 32'd1;
                  if (!data_hit) begin
                     err_d = 1'b1;
                     if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                     if (miss_q == 3'd3) begin
                        state_d  = ST_SEEK;
                        seeded_d = 1'b0;
                        miss_d   = 3'd0;
                        match_d  = 3'd0;
                     end else begin
                        miss_d = miss_q + 3'd1;
                     end
                  end else begin
                     miss_d = 3'd0;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (bus.chk_clr) begin
         err_cnt_d = 16'd0;
         smp_cnt_d = 32'd0;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cfg_q     <= 8'd0;
         exp_q     <= 24'd0;
         match_q   <= 3'd0;
         miss_q    <= 3'd0;
         seeded_q  <= 1'b0;
         lock_q    <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= 16'd0;
         smp_cnt_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         cfg_q     <= bus.cfg_ad_tp;
         exp_q     <= exp_d;
         match_q   <= match_d;
         miss_q    <= miss_d;
         seeded_q  <= seeded_d;
         lock_q    <= (state_d == ST_LOCK);
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         smp_cnt_q <= smp_cnt_d;
      end
   end

   assign bus.chk_lock    = lock_q;
   assign bus.chk_err     = err_q;
   assign bus.chk_err_cnt = err_cnt_q;
   assign bus.chk_smp_cnt = smp_cnt_q;
   assign bus.chk_state   = state_q;

endmodule

// File: doc/ad_tp_chk.md
AD_TP_CHK -- requirements
Module: ad_tp_chk

Interface
REQ-001 SHALL have port clk_sys, input, 1, system clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ad_data, input, 24, AD sample stream under check.
REQ-004 SHALL have port ad_vld, input, 1, single-cycle qualifier for ad_data.
REQ-005 SHALL have port cfg_ad_tp, input, 8, pattern select: 0 off, 1 ramp, 2 alternate, 3 constant, others treated as 0.
REQ-006 SHALL have port chk_clr, input, 1, single-cycle clear of counters.
REQ-007 SHALL have port chk_lock, output, 1, registered; high while in LOCK.
REQ-008 SHALL have port chk_err, output, 1, registered single-cycle mismatch pulse.
REQ-009 SHALL have port chk_err_cnt, output, 16, saturating mismatch count.
REQ-010 SHALL have port chk_smp_cnt, output, 32, saturating count of samples compared in LOCK.

Function
REQ-011 SHALL compute next(x) per mode: ramp x+1 mod 2^24 (0xFFFFFF wraps to 0x000000); alternate x XOR 0xFFFFFF; constant fixed 0x5A5A5A.
REQ-012 SHALL implement states IDLE, SEEK, LOCK; IDLE whenever effective mode is 0.
REQ-013 SHALL move IDLE->SEEK on the cycle after effective mode becomes nonzero; any change of cfg_ad_tp SHALL force SEEK (or IDLE if new mode is 0) next cycle, clearing match/miss runs and seed flag.
REQ-014 SEEK: first ad_vld sample SHALL seed exp <= next(ad_data), no compare.
REQ-015 SEEK: each later ad_vld sample SHALL compare to exp; match increments match_run, mismatch clears match_run; exp <= next(ad_data) either way.
REQ-016 SHALL enter LOCK when match_run reaches 4; chk_lock SHALL rise the cycle after the 5th valid sample (seed + 4 matches).
REQ-017 LOCK: each ad_vld sample SHALL compare to exp and exp <= next(exp) (free-running, not reseeded from data), so a single corrupted sample counts as one error.
REQ-018 LOCK: mismatch SHALL assert chk_err exactly one cycle after the sample, increment chk_err_cnt (hold at 0xFFFF), increment miss_run; match clears miss_run.
REQ-019 LOCK: miss_run reaching 4 consecutive SHALL return to SEEK, drop chk_lock next cycle, clear seed flag.
REQ-020 LOCK: every compared sample SHALL increment chk_smp_cnt (hold at 0xFFFFFFFF).
REQ-021 No SEEK compare SHALL affect chk_err, chk_err_cnt or chk_smp_cnt.
REQ-022 Cycles without ad_vld SHALL leave exp, runs and counters unchanged.
REQ-023 chk_clr SHALL zero chk_err_cnt and chk_smp_cnt next cycle without affecting state; on simultaneous clr and mismatch, clear wins (count 0) but chk_err still pulses.
REQ-024 Mode change coincident with ad_vld SHALL ignore that sample.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, chk_lock 0, chk_err 0, chk_err_cnt 0, chk_smp_cnt 0, exp 0, runs 0, seed flag 0.
REQ-026 Reset deassertion mid-stream SHALL restart from IDLE; no sample seen during reset is retained.

Verification
REQ-027 Mode 1, ramp 0x000010.. on consecutive ad_vld -> chk_lock rises cycle after 0x000014; chk_err_cnt 0.
REQ-028 Mode 1 locked, ramp through 0xFFFFFE,0xFFFFFF,0x000000,0x000001 -> no chk_err, chk_smp_cnt +4.
REQ-029 Mode 2 locked, one sample 0x555554 in place of 0x555555 -> one chk_err pulse, chk_err_cnt 1, lock held, next correct sample matches.
REQ-030 Mode 3 locked, 4 consecutive 0x000000 samples -> chk_err_cnt 4, chk_lock falls after 4th; resume 0x5A5A5A x5 -> relock.
REQ-031 chk_clr same cycle as mismatch with chk_err_cnt 7 -> chk_err pulses, chk_err_cnt 0.
REQ-032 Locked mode 1, cfg_ad_tp to 0 then rst_n pulse mid-stream -> chk_lock 0, IDLE, all counters 0.
